final_soc_pio_in_edge: RTL

FINAL_SOC_PIO_IN_EDGE -- requirements
Module: final_soc_pio_in_edge

---
 rtl/final_soc_pio_pkg.sv | 16 +
 rtl/final_soc_pio_sync.sv | 29 ++
 rtl/final_soc_pio_in_edge.sv | 119 +++++++++++
 3 files changed

// File: rtl/final_soc_pio_pkg.sv
// Shared constants for the PIO edge-capture block: register addresses,
// edge-mode encodings and the event counter width.
package final_soc_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_EVCNT   = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int EVCNT_W = 16;

endpackage

// File: rtl/final_soc_pio_sync.sv
// Multi-flop synchroniser for asynchronous PIO inputs; output is the last stage.
module final_soc_pio_sync #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/final_soc_pio_in_edge.sv
// Avalon-MM PIO input port with edge capture, event counter and level interrupt.
module final_soc_pio_in_edge
  import final_soc_pio_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

  logic [WIDTH-1:0]   sync_q;
  logic [WIDTH-1:0]   prev_q;
  logic [WIDTH-1:0]   raw_edge;
  logic [WIDTH-1:0]   edge_hit;
  logic [WIDTH-1:0]   edgecap_q, edgecap_d;
  logic [WIDTH-1:0]   irqmask_q, irqmask_d;
  logic [EVCNT_W-1:0] evcnt_q, evcnt_d;
  logic [ARM_W-1:0]   arm_q, arm_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               armed;
  logic               any_edge;
  logic               wr_en;

  final_soc_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (in_port),
    .sync_o  (sync_q)
  );

  // Arming holds off detection until the chain and prev_q carry post-reset samples.
  assign armed = (arm_q == ARM_W'(ARM_CYCLES));
  assign arm_d = armed ? arm_q : arm_q + ARM_W'(1);

  always_comb begin
    raw_edge = sync_q ^ prev_q;
    case (EDGE_MODE)
      EDGE_RISE: raw_edge = sync_q & ~prev_q;
      EDGE_FALL: raw_edge = ~sync_q & prev_q;
      default:   raw_edge = sync_q ^ prev_q;
    endcase
  end

  assign edge_hit = armed ? raw_edge : '0;
  assign any_edge = |edge_hit;
  assign wr_en    = chipselect && !write_n;

  always_comb begin
    edgecap_d = edgecap_q;
    if (wr_en && address == ADDR_EDGECAP) begin
      edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    end
    edgecap_d = edgecap_d | edge_hit;
  end

  always_comb begin
    irqmask_d = irqmask_q;
    if (wr_en && address == ADDR_IRQMASK) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
  end

  // A clearing write coincident with an edge leaves the count at one.
  always_comb begin
    evcnt_d = evcnt_q;
    if (wr_en && address == ADDR_EVCNT) begin
      evcnt_d = any_edge ? EVCNT_W'(1) : '0;
    end else if (any_edge && evcnt_q != '1) begin
      evcnt_d = evcnt_q + EVCNT_W'(1);
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d = 32'(sync_q);
      ADDR_EVCNT:   readdata_d = 32'(evcnt_q);
      ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
      default:      readdata_d = 32'(edgecap_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= '0;
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      evcnt_q    <= '0;
      arm_q      <= '0;
      readdata_q <= '0;
    end else begin
      prev_q     <= sync_q;
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      evcnt_q    <= evcnt_d;
      arm_q      <= arm_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule
